// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared types and constants for the instruction loader
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_STRIDE    = 4;

endpackage

// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - byte stream in, instruction memory write port out
interface instr_loader_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);

  logic                   byte_valid;
  logic [7:0]             byte_data;
  logic                   byte_ready;
  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [INSTR_WIDTH-1:0] mem_wdata;

  // Environment side: sources bytes, observes memory writes.
  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader side.
  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/instr_loader_byte_packer.sv
// rtl/instr_loader_byte_packer.sv - little-endian byte-to-word assembler
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_full
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] byte_idx;
  logic [31:0]      shift_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_idx <= '0;
      shift_q  <= '0;
    end else if (accept) begin
      shift_q[8*byte_idx +: 8] <= byte_data;
      byte_idx                 <= byte_idx + 1'b1;
    end
  end

  // Word including the byte being accepted now, so the top can register it
  // on the same edge the fourth byte arrives.
  always_comb begin
    word                    = shift_q;
    word[8*byte_idx +: 8]   = byte_data;
    word_full               = accept && (byte_idx == IDX_W'(BYTES_PER_WORD - 1));
  end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - boot loader writing a byte stream into instruction memory
module instr_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int CNT_WIDTH   = $clog2(DEPTH_WORDS) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] word_count,
  instr_loader_if.slave        bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 cpu_rst
);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   count_q;
  logic [CNT_WIDTH-1:0]   written_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic [INSTR_WIDTH-1:0] mem_wdata_q;
  logic                   err_q;

  logic        start_ok;
  logic        oversize;
  logic        begin_load;
  logic        accept;
  logic [31:0] pk_word;
  logic        pk_full;

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (begin_load),
    .accept    (accept),
    .byte_data (bus.byte_data),
    .word      (pk_word),
    .word_full (pk_full)
  );

  always_comb begin
    state_d    = state_q;
    start_ok   = start && (state_q == IDLE || state_q == DONE);
    oversize   = word_count > CNT_WIDTH'(DEPTH_WORDS);
    begin_load = 1'b0;
    accept     = (state_q == LOAD) && bus.byte_valid;
    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          if (word_count == '0 || oversize) begin
            state_d = DONE;
          end else begin
            state_d    = LOAD;
            begin_load = 1'b1;
          end
        end
      end
      LOAD: begin
        if (pk_full) state_d = WRITE;
      end
      WRITE: begin
        state_d = (written_q + CNT_WIDTH'(1) == count_q) ? DONE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      written_q   <= '0;
      addr_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) err_q <= oversize;
      if (begin_load) begin
        count_q   <= word_count;
        written_q <= '0;
        addr_q    <= '0;
      end
      // Memory-facing registers only change when a word completes, so they
      // hold the last written value outside the write cycle.
      if (pk_full) begin
        mem_addr_q  <= addr_q;
        mem_wdata_q <= pk_word;
      end
      if (state_q == WRITE) begin
        addr_q    <= addr_q + ADDR_WIDTH'(ADDR_STRIDE);
        written_q <= written_q + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.byte_ready = (state_q == LOAD);
  assign bus.mem_we     = (state_q == WRITE);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign busy           = (state_q == LOAD) || (state_q == WRITE);
  assign done           = (state_q == DONE);
  assign err            = err_q;
  assign cpu_rst        = (state_q != DONE);

endmodule
